// File: rtl/scr1_dmem_pkg.sv
// Shared SCR1 data-memory protocol encodings, request payload and target FSM state type.
package scr1_dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_CNT_W  = 3;

  localparam logic DMEM_CMD_RD = 1'b0;
  localparam logic DMEM_CMD_WR = 1'b1;

  localparam logic [1:0] DMEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] DMEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] DMEM_WIDTH_WORD = 2'b10;
  localparam logic [1:0] DMEM_WIDTH_INV  = 2'b11;

  localparam logic [1:0] DMEM_RESP_IDLE = 2'b00;
  localparam logic [1:0] DMEM_RESP_OK   = 2'b01;
  localparam logic [1:0] DMEM_RESP_ER   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_e;

  typedef struct packed {
    logic                   cmd;
    logic [1:0]             width;
    logic                   err;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  // Invalid width or a misaligned half/word access is a protocol error.
  function automatic logic dmem_access_err(input logic [1:0] width, input logic [1:0] off);
    logic err;
    case (width)
      DMEM_WIDTH_BYTE: err = 1'b0;
      DMEM_WIDTH_HALF: err = off[0];
      DMEM_WIDTH_WORD: err = |off;
      default:         err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/scr1_dmem_sram_target_if.sv
// SCR1 dmem request/response bundle between a router port and a target.
interface scr1_dmem_sram_target_if;
  import scr1_dmem_pkg::*;

  logic                   dmem_req;
  logic                   dmem_req_ack;
  logic                   dmem_cmd;
  logic [1:0]             dmem_width;
  logic [31:0]            dmem_addr;
  logic [DMEM_DATA_W-1:0] dmem_wdata;
  logic [DMEM_DATA_W-1:0] dmem_rdata;
  logic [1:0]             dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/scr1_sram_1rw_be.sv
// Synchronous single-port RAM with byte enables; one-cycle read latency, old data on read-during-write.
module scr1_sram_1rw_be
  import scr1_dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DMEM_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/scr1_dmem_sram_target.sv
// SCR1 dmem target: SRAM behind the request/response handshake with wait states and error responses.
module scr1_dmem_sram_target
  import scr1_dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  scr1_dmem_sram_target_if.slave  dmem
);

  localparam int unsigned BA_W    = ADDR_WIDTH + 2;
  localparam bit          NO_WAIT = (WAIT_STATES == 0);
  localparam logic [DMEM_CNT_W-1:0] WAIT_INIT = DMEM_CNT_W'(WAIT_STATES);

  dmem_state_e            state_q, state_d;
  logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]             resp_q, resp_d;
  dmem_req_t              req_q;
  logic [BA_W-1:0]        addr_q;

  logic                   ack;
  logic                   accept;
  logic                   live_err;
  logic                   issue;

  logic                   acc_cmd;
  logic [1:0]             acc_width;
  logic [BA_W-1:0]        acc_addr;
  logic [DMEM_DATA_W-1:0] acc_wdata;
  logic                   acc_err;

  logic [3:0]             sram_be;
  logic [DMEM_DATA_W-1:0] sram_wdata;
  logic [DMEM_DATA_W-1:0] sram_rdata;
  logic                   unused_addr;

  assign unused_addr = ^dmem.dmem_addr[31:BA_W];

  assign ack      = rst_n && (state_q != ST_WAIT);
  assign accept   = dmem.dmem_req && ack;
  assign live_err = dmem_access_err(dmem.dmem_width, dmem.dmem_addr[1:0]);

  // FSM next state, wait counter, SRAM issue and next response code
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = DMEM_RESP_IDLE;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d = ST_RESP;
            issue   = 1'b1;
            resp_d  = live_err ? DMEM_RESP_ER : DMEM_RESP_OK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - DMEM_CNT_W'(1);
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d = ST_RESP;
          issue   = 1'b1;
          resp_d  = req_q.err ? DMEM_RESP_ER : DMEM_RESP_OK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      resp_q  <= DMEM_RESP_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      if (accept) begin
        req_q  <= '{cmd: dmem.dmem_cmd, width: dmem.dmem_width, err: live_err,
                    wdata: dmem.dmem_wdata};
        addr_q <= dmem.dmem_addr[BA_W-1:0];
      end
    end
  end

  // With no wait states the access goes out in the accept cycle, so it uses the live request
  assign acc_cmd   = NO_WAIT ? dmem.dmem_cmd              : req_q.cmd;
  assign acc_width = NO_WAIT ? dmem.dmem_width            : req_q.width;
  assign acc_addr  = NO_WAIT ? dmem.dmem_addr[BA_W-1:0]   : addr_q;
  assign acc_wdata = NO_WAIT ? dmem.dmem_wdata            : req_q.wdata;
  assign acc_err   = NO_WAIT ? live_err                   : req_q.err;

  always_comb begin
    sram_be    = 4'b0000;
    sram_wdata = acc_wdata;
    case (acc_width)
      DMEM_WIDTH_BYTE: begin
        sram_be    = 4'(4'b0001 << acc_addr[1:0]);
        sram_wdata = {4{acc_wdata[7:0]}};
      end
      DMEM_WIDTH_HALF: begin
        sram_be    = 4'(4'b0011 << acc_addr[1:0]);
        sram_wdata = {2{acc_wdata[15:0]}};
      end
      DMEM_WIDTH_WORD: sram_be = 4'b1111;
      default:         sram_be = 4'b0000;
    endcase
  end

  scr1_sram_1rw_be #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .en    (issue && !acc_err),
    .we    (acc_cmd == DMEM_CMD_WR),
    .be    (sram_be),
    .addr  (acc_addr[BA_W-1:2]),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  assign dmem.dmem_req_ack = ack;
  assign dmem.dmem_resp    = resp_q;
  // Read data is only meaningful on a successful read; right-justify the addressed lane
  assign dmem.dmem_rdata   = (resp_q == DMEM_RESP_OK && req_q.cmd == DMEM_CMD_RD)
                             ? (sram_rdata >> {addr_q[1:0], 3'b000}) : '0;

endmodule

// File: tb/tb_scr1_dmem_sram_target.sv
// Scoreboard bench for scr1_dmem_sram_target: one instance with no wait states, one with three.
module tb_scr1_dmem_sram_target;
  import scr1_dmem_pkg::*;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst3_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q3[$];

  scr1_dmem_sram_target_if if0();
  scr1_dmem_sram_target_if if3();

  scr1_dmem_sram_target #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .dmem(if0)
  );
  scr1_dmem_sram_target #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .dmem(if3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic drive(input int d, input logic req, input logic cmd, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.dmem_req = req; if0.dmem_cmd = cmd; if0.dmem_width = w;
      if0.dmem_addr = a;  if0.dmem_wdata = wd;
    end else begin
      if3.dmem_req = req; if3.dmem_cmd = cmd; if3.dmem_width = w;
      if3.dmem_addr = a;  if3.dmem_wdata = wd;
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == 0) ? if0.dmem_req_ack : if3.dmem_req_ack;
  endfunction

  // Present one request, wait (bounded) for acceptance, queue the expected response
  task automatic send(input int d, input logic cmd, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] er, input logic [31:0] erd,
                      input bit push, output int acc, output int waits);
    exp_t e;
    drive(d, 1'b1, cmd, w, a, wd);
    acc = -1;
    waits = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ack_of(d)) begin
        acc = cyc;
        break;
      end
      waits++;
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: dut%0d never accepted addr 0x%08h", d, a);
    end else if (push) begin
      e.resp = er;
      e.rdata = erd;
      e.cyc = acc + 1 + ((d == 0) ? 0 : 3);
      if (d == 0) q0.push_back(e);
      else q3.push_back(e);
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  // Response monitors: every non-idle response must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (if0.dmem_resp != DMEM_RESP_IDLE) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp0: got resp %b rdata 0x%08h", if0.dmem_resp, if0.dmem_rdata);
      end else begin
        e = q0.pop_front();
        chk("w0_resp",  32'(if0.dmem_resp), 32'(e.resp));
        chk("w0_rdata", if0.dmem_rdata, e.rdata);
        chk("w0_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (if3.dmem_resp != DMEM_RESP_IDLE) begin
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp3: got resp %b rdata 0x%08h", if3.dmem_resp, if3.dmem_rdata);
      end else begin
        e = q3.pop_front();
        chk("w3_resp",  32'(if3.dmem_resp), 32'(e.resp));
        chk("w3_rdata", if3.dmem_rdata, e.rdata);
        chk("w3_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int a1, a2, w1, w2;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    chk("rst_ack0",   32'(if0.dmem_req_ack), 32'h0);
    chk("rst_resp0",  32'(if0.dmem_resp), 32'h0);
    chk("rst_rdata0", if0.dmem_rdata, 32'h0);
    chk("rst_ack3",   32'(if3.dmem_req_ack), 32'h0);
    @(posedge clk); #1;
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
    chk("idle_ack0", 32'(if0.dmem_req_ack), 32'h1);
    chk("idle_ack3", 32'(if3.dmem_req_ack), 32'h1);
    @(posedge clk); #1;

    // No wait states: write then back-to-back read of the same word
    send(0, DMEM_CMD_WR, DMEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF, DMEM_RESP_OK, 32'h0, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h10, 32'h0, DMEM_RESP_OK, 32'hDEADBEEF, 1'b1, a2, w2);
    chk("w0_b2b_accept", 32'(a2 - a1), 32'd1);
    chk("w0_ack_stall", 32'(w1 + w2), 32'd0);

    send(0, DMEM_CMD_WR, DMEM_WIDTH_BYTE, 32'h13, 32'h000000A5, DMEM_RESP_OK, 32'h0, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_BYTE, 32'h13, 32'h0, DMEM_RESP_OK, 32'h000000A5, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h10, 32'h0, DMEM_RESP_OK, 32'hA5ADBEEF, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_HALF, 32'h12, 32'h0, DMEM_RESP_OK, 32'h0000A5AD, 1'b1, a1, w1);

    // Error cases: misaligned half write, invalid width, misaligned word read
    send(0, DMEM_CMD_WR, DMEM_WIDTH_HALF, 32'h11, 32'h00001234, DMEM_RESP_ER, 32'h0, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_INV,  32'h10, 32'h0, DMEM_RESP_ER, 32'h0, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h12, 32'h0, DMEM_RESP_ER, 32'h0, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h10, 32'h0, DMEM_RESP_OK, 32'hA5ADBEEF, 1'b1, a1, w1);

    // Aliasing above bit 11, then a byte write into lane 1
    send(0, DMEM_CMD_WR, DMEM_WIDTH_WORD, 32'h00001010, 32'h11223344, DMEM_RESP_OK, 32'h0, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h00000010, 32'h0, DMEM_RESP_OK, 32'h11223344, 1'b1, a1, w1);
    send(0, DMEM_CMD_WR, DMEM_WIDTH_BYTE, 32'h11, 32'h00000077, DMEM_RESP_OK, 32'h0, 1'b1, a1, w1);
    send(0, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h10, 32'h0, DMEM_RESP_OK, 32'h11227744, 1'b1, a1, w1);

    // Three wait states: second request stalls until the first response cycle
    send(3, DMEM_CMD_WR, DMEM_WIDTH_WORD, 32'h10, 32'hCAFEF00D, DMEM_RESP_OK, 32'h0, 1'b1, a1, w1);
    send(3, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h10, 32'h0, DMEM_RESP_OK, 32'hCAFEF00D, 1'b1, a2, w2);
    chk("w3_b2b_accept", 32'(a2 - a1), 32'd4);
    chk("w3_ack_low_cycles", 32'(w2), 32'd3);
    repeat (6) @(posedge clk);
    #1;

    // Reset during WAIT drops the pending read
    send(3, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h20, 32'h0, DMEM_RESP_OK, 32'h0, 1'b0, a1, w1);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("w3_rst_resp", 32'(if3.dmem_resp), 32'h0);
      chk("w3_rst_ack",  32'(if3.dmem_req_ack), 32'h0);
    end
    @(posedge clk); #1;
    rst3_n = 1'b1;
    @(negedge clk);
    chk("w3_post_rst_ack", 32'(if3.dmem_req_ack), 32'h1);
    @(posedge clk); #1;
    send(3, DMEM_CMD_RD, DMEM_WIDTH_WORD, 32'h10, 32'h0, DMEM_RESP_OK, 32'hCAFEF00D, 1'b1, a1, w1);

    repeat (12) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q3_drained", 32'(q3.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scr1_dmem_sram_target.md
Name: scr1_dmem_sram_target

Overview:
- Responder (target) end of the SCR1 data-memory request/response protocol.
- Hangs off one router port, e.g. port1 of the dmem router.
- Implements a single-port SRAM with byte/half/word access, configurable wait states and protocol error responses.
- Supports back-to-back pipelined requests: a new request is accepted in the same cycle a response is driven.

Parameters:
- ADDR_WIDTH, 10, word-address bits. Capacity is 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- WAIT_STATES, 0, extra cycles between accept and response. Legal range 0..7.

Ports:
- rst_n  in  1  asynchronous reset, active low
- clk  in  1  clock
- dmem_req  in  1  request valid
- dmem_req_ack  out  1  request accepted this cycle
- dmem_cmd  in  1  0 = read, 1 = write
- dmem_width  in  2  00 = byte, 01 = half, 10 = word, 11 = invalid
- dmem_addr  in  32  byte address. Only bits [ADDR_WIDTH+1:0] are used.
- dmem_wdata  in  32  write data, LSB-aligned
- dmem_rdata  out  32  read data, LSB-aligned, valid only with resp = 01 on a read
- dmem_resp  out  2  00 = none, 01 = OK, 10 = ERROR

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset state: IDLE, dmem_resp = 00, dmem_rdata = 0, wait counter = 0.
  - dmem_req_ack is forced to 0 while rst_n is low.
  - SRAM contents are not reset.
- Handshake:
  - A transfer is accepted when dmem_req & dmem_req_ack.
  - dmem_req_ack = 1 in IDLE and RESP, 0 in WAIT. It is combinational and independent of dmem_req.
  - On accept, cmd, width, addr[ADDR_WIDTH+1:0] and wdata are registered.
- FSM:
  - IDLE: on accept, go to RESP if WAIT_STATES = 0, else go to WAIT with counter = WAIT_STATES.
  - WAIT: decrement counter each cycle. When counter reaches 1, issue the SRAM access and go to RESP next cycle.
  - RESP: dmem_resp driven for exactly one cycle.
    - If a new request is accepted in this cycle, go to RESP (W = 0) or WAIT (W > 0).
    - Otherwise go to IDLE.
- Latency:
  - Accept at cycle N gives a response at cycle N+1+WAIT_STATES.
  - The SRAM access is issued in cycle N+WAIT_STATES, i.e. the accept cycle when W = 0, using the captured values (or live values when W = 0).
  - Read data appears from the synchronous SRAM in the response cycle.
- Error detection (decided at accept):
  - width = 11 → error.
  - half with addr[0] = 1 → error.
  - word with addr[1:0] ≠ 00 → error.
  - An error suppresses the SRAM write, gives resp = 10 and rdata = 0, with the same latency as OK.
- Address:
  - Upper bits above ADDR_WIDTH+1 are ignored, so accesses alias. The router has already decoded the base.
- Write lanes:
  - byte: be = 0001 << addr[1:0], data = {4{wdata[7:0]}}.
  - half: be = 0011 << addr[1:0], data = {2{wdata[15:0]}}.
  - word: be = 1111, data = wdata.
- Read return:
  - rdata = word >> (8*addr[1:0]), zero-filled at the top. Sign/zero extension is done by the LSU.
- Output gating:
  - dmem_rdata = 0 whenever resp ≠ 01 or the command was a write.
  - dmem_resp = 00 outside RESP.
- Ordering: a write followed back-to-back by a read of the same word returns the new data. The sync RAM write completes before the read access cycle.
- Reset mid-operation:
  - A pending WAIT or RESP is dropped and no response is issued.
  - A write already issued to the SRAM may have completed. Its contents are undefined to the initiator.
- Simultaneous events: in RESP with dmem_req = 1, the response and the new accept occur in the same cycle. No bubble when W = 0.

Decomposition:
- Package scr1_dmem_pkg holds the shared protocol encodings:
  - cmd constants: RD = 0, WR = 1.
  - width constants: BYTE, HALF, WORD, INV.
  - resp constants: IDLE = 00, OK = 01, ER = 10.
  - FSM state type.
- Sub-module scr1_sram_1rw_be: synchronous single-port RAM, 2^ADDR_WIDTH x 32, 4-bit byte enable, one-cycle read latency, read-during-write returns old data (never exercised by this FSM).
- The target FSM, lane logic and error check live in the top module.

Test Plan:
- W = 0: write word 0xDEADBEEF to 0x10, then read 0x10 accepted in the RESP cycle → write resp = 01 at N+1, read resp = 01 at N+2 with rdata = 0xDEADBEEF, req_ack = 1 throughout.
- Byte write 0x000000A5 to 0x13, then byte read 0x13 and word read 0x10 → rdata = 0x000000A5, then 0xA5ADBEEF.
- Half write to 0x11, then width = 11 read of 0x10 → both resp = 10 with rdata = 0. A following word read of 0x10 returns 0xA5ADBEEF (unchanged).
- WAIT_STATES = 3: accept at cycle N → req_ack = 0 and resp = 00 during N+1..N+3, resp = 01 at N+4. A back-to-back second request is accepted at N+4 and responds at N+8.
- ADDR_WIDTH = 10: write 0x11223344 to 0x00001010, read 0x00000010 → rdata = 0x11223344 (aliasing).
- WAIT_STATES = 3: assert rst_n low at N+2 → resp stays 00 and req_ack = 0 during reset. After release, IDLE with req_ack = 1, and a new read of 0x10 completes with resp = 01.
